// File: rtl/pwm_pkg.sv
// ============================================================================
// Module      : pwm_pkg
// Description : Shared state encoding and counter limits for the PWM compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ARMED    = 2'd1,
        RUN      = 2'd2,
        RUN_PEND = 2'd3
    } pwm_state_t;

    localparam int PWM_WIDTH = 8;

    // Terminal count of a WIDTH-bit free-running counter.
    function automatic int cnt_max(input int width);
        return (1 << width) - 1;
    endfunction

    localparam int CNT_MAX = cnt_max(PWM_WIDTH);

endpackage

`default_nettype wire

// File: rtl/pwm_compare.sv
// ============================================================================
// Module      : pwm_compare
// Description : Shadow-buffered duty compare against a free-running counter,
//               producing a registered PWM output and a period-boundary pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pwm_compare
    import pwm_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count,
    input  logic             count_en,
    input  logic [WIDTH-1:0] duty_in,
    input  logic             duty_valid,
    output logic             duty_ready,
    output logic             pwm_out,
    output logic             period_done
);

    localparam logic [WIDTH-1:0] c_cnt_max = WIDTH'(cnt_max(WIDTH));

    pwm_state_t       r_state;
    logic [WIDTH-1:0] r_duty_active;
    logic [WIDTH-1:0] r_duty_pend;
    logic             r_pwm_out;
    logic             r_period_done;

    logic             w_wrap;
    logic             w_accept;
    logic             w_active;

    // A stalled counter sitting at MAX is not a boundary; only an advancing one is.
    assign w_wrap     = count_en && (count == c_cnt_max);
    assign duty_ready = (r_state == IDLE) || (r_state == RUN);
    assign w_accept   = duty_valid && duty_ready;
    assign w_active   = (r_state == RUN) || (r_state == RUN_PEND);

    assign pwm_out     = r_pwm_out;
    assign period_done = r_period_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_duty_active <= '0;
            r_duty_pend   <= '0;
            r_pwm_out     <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_period_done <= w_wrap;
            // Compare uses pre-edge state/duty, so the swap on a wrap edge
            // first shows up in the compare against count 0.
            r_pwm_out     <= w_active && (count < r_duty_active);

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_duty_pend <= duty_in;
                        r_state     <= ARMED;
                    end
                end
                ARMED: begin
                    if (w_wrap) begin
                        r_duty_active <= r_duty_pend;
                        r_state       <= RUN;
                    end
                end
                RUN: begin
                    // An accept coinciding with a wrap waits for the next wrap.
                    if (w_accept) begin
                        r_duty_pend <= duty_in;
                        r_state     <= RUN_PEND;
                    end
                end
                RUN_PEND: begin
                    if (w_wrap) begin
                        r_duty_active <= r_duty_pend;
                        r_state       <= RUN;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pwm_compare.sv
// ============================================================================
// Module      : tb_pwm_compare
// Description : Directed, table-driven self-checking bench for pwm_compare.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pwm_compare;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] count;
    logic       count_en;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       duty_ready;
    logic       pwm_out;
    logic       period_done;

    int n_tests = 0;
    int n_fail  = 0;

    pwm_compare #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .count       (count),
        .count_en    (count_en),
        .duty_in     (duty_in),
        .duty_valid  (duty_valid),
        .duty_ready  (duty_ready),
        .pwm_out     (pwm_out),
        .period_done (period_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] duty;
        int         exp_high;
        int         exp_first_low;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock; the bench models the upstream counter advancing on the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (count_en) count = count + 8'd1;
    endtask

    task automatic advance_to(input logic [7:0] target, output int highs);
        highs = 0;
        for (int k = 0; k < 600; k++) begin
            if (count == target) return;
            step();
            highs += int'(pwm_out);
        end
        chk("advance_to_timeout", int'(count), int'(target));
    endtask

    task automatic send(input logic [7:0] d);
        logic rdy;
        duty_in    = d;
        duty_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            rdy = duty_ready;
            step();
            if (rdy) begin
                duty_valid = 1'b0;
                return;
            end
        end
        duty_valid = 1'b0;
        chk("send_timeout", 0, 1);
    endtask

    // Observes one full period starting at count 0; sample i reflects count i.
    task automatic measure(input int send_at, input logic [7:0] send_val, input int junk_at,
                           output int highs, output int first_low, output int pds);
        logic rdy;
        highs = 0; first_low = -1; pds = 0;
        for (int i = 0; i < 256; i++) begin
            if (i == send_at) begin duty_in = send_val; duty_valid = 1'b1; end
            if (i == junk_at) begin duty_in = 8'd7;     duty_valid = 1'b1; end
            if (i == junk_at + 5) duty_valid = 1'b0;
            rdy = duty_ready;
            step();
            if (duty_valid && rdy) duty_valid = 1'b0;
            highs += int'(pwm_out);
            if (!pwm_out && first_low < 0) first_low = i;
            pds += int'(period_done);
        end
    endtask

    initial begin
        int h, fl, pd, tmp;

        vecs[0] = '{duty: 8'd0,   exp_high: 0,   exp_first_low: 0};
        vecs[1] = '{duty: 8'd1,   exp_high: 1,   exp_first_low: 1};
        vecs[2] = '{duty: 8'd128, exp_high: 128, exp_first_low: 128};
        vecs[3] = '{duty: 8'd64,  exp_high: 64,  exp_first_low: 64};
        vecs[4] = '{duty: 8'd255, exp_high: 255, exp_first_low: 255};

        reset = 1'b1; count = 8'd0; count_en = 1'b0; duty_in = 8'd0; duty_valid = 1'b0;
        step(); step(); step();
        chk("rst_pwm", int'(pwm_out), 0);
        chk("rst_ready", int'(duty_ready), 1);
        chk("rst_pd", int'(period_done), 0);
        reset = 1'b0;
        count_en = 1'b1;

        measure(-1, 8'd0, -100, h, fl, pd);
        chk("idle_high", h, 0);
        chk("idle_pd", pd, 1);

        // From IDLE: duty 64 armed at count 10, takes effect after the wrap.
        advance_to(8'd10, tmp);
        send(8'd64);
        chk("armed_ready", int'(duty_ready), 0);
        advance_to(8'd0, h);
        chk("armed_high", h, 0);
        measure(-1, 8'd0, -100, h, fl, pd);
        chk("first64_high", h, 64);
        chk("first64_low", fl, 64);
        chk("first64_pd", pd, 1);
        chk("run_ready", int'(duty_ready), 1);

        // Mid-period update to 200, plus an ignored valid while not ready.
        measure(100, 8'd200, 150, h, fl, pd);
        chk("keep64_high", h, 64);
        measure(-1, 8'd0, -100, h, fl, pd);
        chk("new200_high", h, 200);
        chk("new200_low", fl, 200);

        // Accept coinciding with the wrap edge defers by one period.
        measure(50, 8'd32, -100, h, fl, pd);
        chk("pre32_high", h, 200);
        measure(255, 8'd128, -100, h, fl, pd);
        chk("wrapacc_cur", h, 32);
        chk("wrapacc_ready", int'(duty_ready), 0);
        measure(-1, 8'd0, -100, h, fl, pd);
        chk("wrapacc_next", h, 32);
        measure(-1, 8'd0, -100, h, fl, pd);
        chk("wrapacc_later", h, 128);

        for (int v = 0; v < 5; v++) begin
            measure(20, vecs[v].duty, -100, h, fl, pd);
            measure(-1, 8'd0, -100, h, fl, pd);
            chk($sformatf("vec%0d_high", v), h, vecs[v].exp_high);
            chk($sformatf("vec%0d_low", v), fl, vecs[v].exp_first_low);
            chk($sformatf("vec%0d_pd", v), pd, 1);
        end

        // Stall at MAX with duty 10 pending: no wrap, no swap, steady output.
        advance_to(8'd20, tmp);
        send(8'd10);
        advance_to(8'd255, tmp);
        count_en = 1'b0;
        h = 0; pd = 0;
        for (int k = 0; k < 20; k++) begin
            step();
            h  += int'(pwm_out);
            pd += int'(period_done);
        end
        chk("stall_pwm", h, 0);
        chk("stall_pd", pd, 0);
        chk("stall_ready", int'(duty_ready), 0);
        chk("stall_count", int'(count), 255);
        count_en = 1'b1;
        step();
        chk("unstall_pd", int'(period_done), 1);
        measure(-1, 8'd0, -100, h, fl, pd);
        chk("after_stall_high", h, 10);

        // Asynchronous reset in RUN_PEND (active 100, pending 50).
        measure(20, 8'd100, -100, h, fl, pd);
        advance_to(8'd20, tmp);
        send(8'd50);
        advance_to(8'd30, tmp);
        chk("pre_rst_pwm", int'(pwm_out), 1);
        chk("pre_rst_ready", int'(duty_ready), 0);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_pwm", int'(pwm_out), 0);
        chk("async_rst_ready", int'(duty_ready), 1);
        count_en = 1'b0;
        count    = 8'd0;
        step(); step();
        reset    = 1'b0;
        count_en = 1'b1;
        measure(-1, 8'd0, -100, h, fl, pd);
        chk("post_rst_high", h, 0);
        chk("post_rst_pd", pd, 1);
        measure(10, 8'd50, -100, h, fl, pd);
        chk("post_rst_armed", h, 0);
        measure(-1, 8'd0, -100, h, fl, pd);
        chk("post_rst_50", h, 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pwm_compare.md
Name: pwm_compare

Overview:
- Downstream consumer of the 8-bit free-running counter.
- Compares the live counter value against a shadow-buffered duty value to produce a registered PWM output and a one-cycle period-boundary pulse.
- New duty values arrive over a valid/ready handshake and take effect only at a counter wrap, so no glitched or partial periods reach the output.

Parameters:
- WIDTH, 8, counter and duty width; period = 2**WIDTH counter steps.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- count  input  WIDTH  live counter value, from the counter's count output.
- count_en  input  1  same enable that drives the counter; high = count advances on this edge.
- duty_in  input  WIDTH  requested duty (number of high counts per period).
- duty_valid  input  1  duty_in is valid.
- duty_ready  output  1  block can accept duty_in this cycle.
- pwm_out  output  1  registered PWM output.
- period_done  output  1  one-cycle pulse marking a counter wrap.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on port reset.
- Reset values: state=IDLE, duty_active=0, duty_pend=0, pwm_out=0, period_done=0. duty_ready is combinational from state, so it reads 1 in reset.
- Wrap: wrap = count_en && (count == 2**WIDTH-1). It is the only period boundary.
  - A counter reset to 0 is not a wrap.
  - count==MAX with count_en=0 is not a wrap.
- period_done is registered: high for exactly the cycle after a wrap edge, in every state.
- Handshake: accept = duty_valid && duty_ready. duty_in is captured into duty_pend on the accept edge. duty_valid while duty_ready=0 is ignored, with no capture. Sources hold valid until ready.
- FSM states:
  - IDLE: no active duty. duty_ready=1. accept -> ARMED.
  - ARMED: pending duty, none active. duty_ready=0. wrap -> duty_active<=duty_pend, go to RUN.
  - RUN: active duty. duty_ready=1. accept -> RUN_PEND.
  - RUN_PEND: active plus pending. duty_ready=0. wrap -> duty_active<=duty_pend, go to RUN.
- Simultaneous accept and wrap in RUN: wrap has nothing pending, so duty_active is unchanged. The new duty goes to RUN_PEND and applies at the following wrap. Same rule applies in IDLE: the result is ARMED, not RUN.
- pwm_out, registered with 1-cycle latency from count:
  - Next value = (state is RUN or RUN_PEND) && (count < duty_active), using the state/duty_active in effect before the edge.
  - The duty update happens on the wrap edge, so the compare against count=0 already uses the new duty.
- Duty boundary values:
  - duty=0: pwm_out is low all period.
  - duty=2**WIDTH-1: high for every count except MAX.
  - 100% duty is not representable.
- Stalled counter (count_en=0): pwm_out holds its level by construction, since count is unchanged; no wrap occurs.
- Arithmetic: unsigned compare only, WIDTH bits, no extension.
- Reset mid-operation: asynchronously returns to reset values. Any pending duty is lost and the source must re-send.

Decomposition:
- Shared package pwm_pkg holds:
  - the state enum (IDLE, ARMED, RUN, RUN_PEND), 2-bit;
  - the constant CNT_MAX = 2**WIDTH-1, defined as a function of width.
- No sub-module. Wrap detect, FSM and compare stay in one module, about 150 lines.

Test Plan:
- Reset held, then released; counter enabled -> pwm_out=0, duty_ready=1, period_done pulses once per 256 enabled cycles, 1 cycle after count goes 255->0.
- From IDLE, send duty 64 at count=10 -> duty_ready drops; pwm_out stays 0 until the wrap. The next period shows pwm_out high for counts 0..63 (64 cycles), each 1 cycle late; state RUN, duty_ready=1.
- In RUN with duty 64, send duty 200 mid-period -> current period keeps 64 high cycles, next period has 200. A second duty_valid while duty_ready=0 is not captured.
- Accept duty 128 on the exact wrap cycle while RUN at duty 32 -> the period after the wrap is still 32; 128 applies one period later.
- Edge values: duty 0 -> no high cycle; duty 255 -> 255 high, 1 low. count_en held low at count=255 for 20 cycles -> no period_done, no duty swap, pwm_out constant.
- Assert reset asynchronously mid-period in RUN_PEND (active 100, pending 50) -> pwm_out=0 immediately, state IDLE; after release, no output until a new duty is sent and a wrap occurs.
